// File: rtl/ccd_pkg.sv
// Shared defaults for the ccd single-entry mailbox register.
// Holds the default word width, synchronizer depth and the data reset value.
package ccd_pkg;

    localparam int CCD_WIDTH       = 8;
    localparam int CCD_SYNC_STAGES = 2;

    localparam logic [CCD_WIDTH-1:0] CCD_DATA_RST = '0;

endpackage : ccd_pkg

// File: rtl/ccd_sync_bit.sv
// Single-bit flop chain with async active-low reset.
// Carries a handshake toggle between the write side and the read side.
module ccd_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) begin
                chain[i] <= chain[i-1];
            end
            chain[0] <= d;
        end
    end

    assign q = chain[STAGES-1];

endmodule : ccd_sync_bit

// File: rtl/ccd_register_sc.sv
// Single-entry mailbox: one word moves from producer to consumer over a
// toggle req/ack handshake whose latency matches a clock-crossing register.
module ccd_register_sc
    import ccd_pkg::*;
#(
    parameter int WIDTH       = CCD_WIDTH,
    parameter int SYNC_STAGES = CCD_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             ready
);

    localparam logic [WIDTH-1:0] DATA_RST = WIDTH'(CCD_DATA_RST);

    logic [WIDTH-1:0] data_q;
    logic             req_t;
    logic             ack_t;
    logic             req_sync;
    logic             ack_sync;
    logic             req_seen;
    logic             ack_seen;
    logic             wr_acc;
    logic             rd_acc;
    logic             req_evt;
    logic             ack_evt;

    assign wr_acc  = we & ~busy;
    assign rd_acc  = re & ready;
    assign req_evt = req_sync ^ req_seen;
    assign ack_evt = ack_sync ^ ack_seen;

    ccd_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (req_t),
        .q       (req_sync)
    );

    ccd_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ack_t),
        .q       (ack_sync)
    );

    // Write side: capture, raise request, wait for the acknowledge to return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= DATA_RST;
            req_t    <= 1'b0;
            busy     <= 1'b0;
            ack_seen <= 1'b0;
        end else begin
            ack_seen <= ack_sync;
            if (wr_acc) begin
                data_q <= din;
                req_t  <= ~req_t;
                busy   <= 1'b1;
            end else if (ack_evt) begin
                busy <= 1'b0;
            end
        end
    end

    // Read side: a request edge delivers the word; a read hands back the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout     <= DATA_RST;
            ready    <= 1'b0;
            ack_t    <= 1'b0;
            req_seen <= 1'b0;
        end else begin
            req_seen <= req_sync;
            if (req_evt) begin
                dout  <= data_q;
                ready <= 1'b1;
            end else if (rd_acc) begin
                ready <= 1'b0;
                ack_t <= ~ack_t;
            end
        end
    end

endmodule : ccd_register_sc

// File: tb/tb_ccd_register_sc.sv
// Bench for ccd_register_sc: directed handshake scenarios followed by random
// traffic, compared every cycle against a cycle-timeline reference model.
module tb_ccd_register_sc;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         we;
    logic         re;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         busy;
    logic         ready;

    always #5 clk = ~clk;

    ccd_register_sc #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .din     (din),
        .busy    (busy),
        .re      (re),
        .dout    (dout),
        .ready   (ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the word in flight plus the absolute edge numbers at
    // which ready is due to rise and busy is due to fall.
    logic         m_busy;
    logic         m_ready;
    logic [W-1:0] m_dout;
    logic [W-1:0] m_word;
    int           cyc;
    int           ready_at;
    int           clr_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_ready  = 1'b0;
        m_dout   = '0;
        m_word   = '0;
        ready_at = -1;
        clr_at   = -1;
    endtask

    task automatic model_edge();
        logic wacc, racc;
        cyc++;
        wacc = we && !m_busy;
        racc = re && m_ready;
        if (wacc) begin
            m_word   = din;
            m_busy   = 1'b1;
            ready_at = cyc + S + 1;
        end
        if (racc) begin
            m_ready = 1'b0;
            clr_at  = cyc + S + 1;
        end
        if (cyc == ready_at) begin
            m_ready = 1'b1;
            m_dout  = m_word;
        end
        if (cyc == clr_at) m_busy = 1'b0;
    endtask

    task automatic compare();
        chk("busy",  32'(busy),  32'(m_busy));
        chk("ready", 32'(ready), 32'(m_ready));
        chk("dout",  32'(dout),  32'(m_dout));
        chk("ready_implies_busy", 32'(ready & ~busy), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        cyc     = 0;
        reset_n = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        din     = '0;
        model_reset();

        // 1: reset held, then released with idle inputs
        #100;
        compare();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();

        // 2: single write, ready exactly S+1 edges later
        din = 8'hA5; we = 1'b1;
        step();
        we = 1'b0;
        chk("t2_busy_next", 32'(busy), 32'd1);
        chk("t2_ready_low", 32'(ready), 32'd0);
        repeat (S) step();
        chk("t2_ready_early", 32'(ready), 32'd0);
        step();
        chk("t2_ready", 32'(ready), 32'd1);
        chk("t2_dout", 32'(dout), 32'hA5);

        // 3: read, busy clears exactly S+1 edges later
        re = 1'b1;
        step();
        re = 1'b0;
        chk("t3_ready_low", 32'(ready), 32'd0);
        repeat (S) step();
        chk("t3_busy_held", 32'(busy), 32'd1);
        step();
        chk("t3_busy_clr", 32'(busy), 32'd0);
        chk("t3_dout_hold", 32'(dout), 32'hA5);

        // 4: write while busy is ignored, next write after busy clears
        din = 8'hA5; we = 1'b1;
        step();
        din = 8'h5A;
        repeat (S + 1) step();
        we = 1'b0;
        chk("t4_ready", 32'(ready), 32'd1);
        chk("t4_dout", 32'(dout), 32'hA5);
        re = 1'b1;
        step();
        re = 1'b0;
        for (int i = 0; i < 20 && busy; i++) step();
        chk("t4_busy_clr", 32'(busy), 32'd0);
        din = 8'h3C; we = 1'b1;
        step();
        we = 1'b0;
        repeat (S + 1) step();
        chk("t4_dout2", 32'(dout), 32'h3C);
        re = 1'b1;
        step();
        re = 1'b0;
        repeat (S + 1) step();

        // 5: read with nothing ready
        re = 1'b1;
        repeat (2) step();
        re = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(ready), 32'd0);
        chk("t5_dout", 32'(dout), 32'h3C);

        // 6: async reset while ready, then a fresh transfer
        din = 8'h11; we = 1'b1;
        step();
        we = 1'b0;
        repeat (S + 1) step();
        chk("t6_ready_pre", 32'(ready), 32'd1);
        #2 reset_n = 1'b0;
        #1 model_reset();
        chk("t6_busy_async", 32'(busy), 32'd0);
        chk("t6_ready_async", 32'(ready), 32'd0);
        chk("t6_dout_async", 32'(dout), 32'd0);
        step();
        reset_n = 1'b1;
        din = 8'h77; we = 1'b1;
        step();
        we = 1'b0;
        repeat (S + 1) step();
        chk("t6_ready", 32'(ready), 32'd1);
        chk("t6_dout", 32'(dout), 32'h77);
        re = 1'b1;
        step();
        re = 1'b0;

        // random traffic with occasional asynchronous resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                we = 1'b0;
                re = 1'b0;
                #1 reset_n = 1'b0;
                #1 model_reset();
                compare();
                repeat ($urandom_range(1, 2)) step();
                reset_n = 1'b1;
            end else begin
                we  = 1'($urandom_range(0, 1));
                re  = 1'($urandom_range(0, 1));
                din = W'($urandom);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ccd_register_sc
